// File: rtl/alu.sv
// Registered signed two's-complement adder/subtractor with signed-overflow flag.
// One-cycle latency, full throughput; synchronous active-high reset clears all outputs.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             h,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             overflow,
  output logic [WIDTH-1:0] result,
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_operand;
  logic [WIDTH:0]   carry_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_next;
  logic             overflow_next;

  // Subtraction reuses the adder as a + ~b + 1; b = most-negative needs no special case.
  assign b_operand = h ? ~b : b;
  assign carry_in  = {{WIDTH{1'b0}}, h};
  assign sum       = {1'b0, a} + {1'b0, b_operand} + carry_in;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    result_next   = sum[WIDTH-1:0];
    overflow_next = 1'b0;
    if (h) begin
      overflow_next = (a[MSB] != b[MSB]) && (result_next[MSB] != a[MSB]);
    end else begin
      overflow_next = (a[MSB] == b[MSB]) && (result_next[MSB] != a[MSB]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= result_next;
        overflow <= overflow_next;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed results, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_alu;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             h;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             overflow;
  logic [WIDTH-1:0] result;
  logic             out_valid;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .h        (h),
    .a        (a),
    .b        (b),
    .overflow (overflow),
    .result   (result),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one valid operation on the falling edge and queue its expected response.
  task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                    input logic th, input logic [WIDTH-1:0] er, input logic eo);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    h = th;
    e.result   = er;
    e.overflow = eo;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    h = 1'($urandom);
  endtask

  // Monitor: every presented output must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.result));
          check("overflow", 32'(overflow), 32'(e.overflow));
        end
      end
    end
  end

  initial begin
    int budget;
    reset    = 1'b1;
    in_valid = 1'b1;
    h        = 1'b0;
    a        = 16'h1234;
    b        = 16'h4321;

    // Reset held for two edges with valid inputs present.
    @(negedge clk);
    @(negedge clk);
    check("reset_result", 32'(result), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;

    // Negative overflow wraps positive; subtract of same operands does not overflow.
    op(16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
    op(16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0);
    // Back-to-back h toggles 0/1/0/1/0.
    op(16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
    op(16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0);
    op(16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
    op(16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0);
    op(16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b1);

    // Positive overflow, subtract of most-negative, plain subtract.
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
    op(16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1);
    op(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0);

    // Capture then three idle cycles with changing operands: outputs hold.
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i > 0) begin
        check("hold_out_valid", 32'(out_valid), 32'h0);
        check("hold_result", 32'(result), 32'h0007);
        check("hold_overflow", 32'(overflow), 32'h0);
      end
    end
    @(negedge clk);
    check("hold_out_valid", 32'(out_valid), 32'h0);
    check("hold_result", 32'(result), 32'h0007);
    check("hold_overflow", 32'(overflow), 32'h0);

    // Reset in the cycle after a capture clears everything on the next edge.
    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    a        = 16'h7FFF;
    b        = 16'h7FFF;
    h        = 1'b0;
    @(negedge clk);
    check("midreset_result", 32'(result), 32'h0);
    check("midreset_overflow", 32'(overflow), 32'h0);
    check("midreset_out_valid", 32'(out_valid), 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    op(16'hFFFE, 16'hFFFF, 1'b0, 16'hFFFD, 1'b0);
    idle();

    // Drain: every queued expectation must be consumed within a bounded wait.
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
